// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score path: FSM states, winner LED codes, BCD width.
package pong_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Score after one more point, pinned at the two-digit ceiling.
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : (v + 7'd1);
    endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit saturating BCD counter with a parallel binary copy of the count for compares.
module bcd_counter_2d
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens,
    output logic [6:0]       value
);

    logic [BCD_W-1:0] ones_r;
    logic [BCD_W-1:0] tens_r;
    logic [6:0]       value_r;
    logic             at_max_s;

    // Saturation flag: 99 is the last representable score.
    always_comb begin
        at_max_s = (tens_r == 4'd9) && (ones_r == 4'd9);
    end

    // Digit and binary count registers; ones rolls into tens, nothing rolls past 99.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            ones_r  <= 4'd0;
            tens_r  <= 4'd0;
            value_r <= 7'd0;
        end else if (inc && !at_max_s) begin
            if (ones_r == 4'd9) begin
                ones_r <= 4'd0;
                tens_r <= tens_r + 4'd1;
            end else begin
                ones_r <= ones_r + 4'd1;
            end
            value_r <= value_r + 7'd1;
        end
    end

    assign ones  = ones_r;
    assign tens  = tens_r;
    assign value = value_r;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: point edge detect, BCD scores, win detect and serve hold-off with req/ack.
// Optional build macro SCORE_KEEPER_WIN_BY_TWO_EN requires a two-point lead (99 always wins).
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 50000000,
    parameter int DLY_W       = 26
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             pause,
    input  logic             point_1,
    input  logic             point_2,
    input  logic             serve_ack,
    output logic             serve_req,
    output logic             serve_dir,
    output logic [BCD_W-1:0] score_1_ones,
    output logic [BCD_W-1:0] score_1_tens,
    output logic [BCD_W-1:0] score_2_ones,
    output logic [BCD_W-1:0] score_2_tens,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SERVE_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [DLY_W-1:0] DLY_ZERO = DLY_W'(0);
    localparam logic [6:0]       WIN_VAL  = 7'(WIN_SCORE);

    state_t           state_r;
    logic [DLY_W-1:0] dly_cnt_r;
    logic             p1_prev_r;
    logic             p2_prev_r;
    logic             serve_req_r;
    logic             serve_dir_r;
    logic             game_over_r;
    logic [1:0]       winner_r;

    logic             ev1_s;
    logic             ev2_s;
    logic             inc1_s;
    logic             inc2_s;
    logic [6:0]       s1_val_s;
    logic [6:0]       s2_val_s;
    logic [6:0]       s1_next_s;
    logic [6:0]       s2_next_s;
    logic             win1_s;
    logic             win2_s;

    // Point strobes are only accepted in PLAY while not paused; player 1 wins a tie.
    always_comb begin
        ev1_s  = point_1 && !p1_prev_r;
        ev2_s  = point_2 && !p2_prev_r;
        inc1_s = 1'b0;
        inc2_s = 1'b0;
        if ((state_r == ST_PLAY) && !pause) begin
            inc1_s = ev1_s;
            inc2_s = ev2_s && !ev1_s;
        end else begin
            inc1_s = 1'b0;
            inc2_s = 1'b0;
        end
    end

    // Win rule evaluated on the score each player would have after this point.
    always_comb begin
        s1_next_s = sat_inc(s1_val_s);
        s2_next_s = sat_inc(s2_val_s);
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
        win1_s = ((s1_next_s >= WIN_VAL) && (s1_next_s >= (s2_val_s + 7'd2))) ||
                 (s1_next_s == SCORE_MAX);
        win2_s = ((s2_next_s >= WIN_VAL) && (s2_next_s >= (s1_val_s + 7'd2))) ||
                 (s2_next_s == SCORE_MAX);
`else
        win1_s = (s1_next_s == WIN_VAL);
        win2_s = (s2_next_s == WIN_VAL);
`endif
    end

    bcd_counter_2d u_score_1 (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (inc1_s),
        .ones    (score_1_ones),
        .tens    (score_1_tens),
        .value   (s1_val_s)
    );

    bcd_counter_2d u_score_2 (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (inc2_s),
        .ones    (score_2_ones),
        .tens    (score_2_tens),
        .value   (s2_val_s)
    );

    // Game sequencing: hold-off count, serve handshake, point outcome and game end.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || clear) begin
            state_r     <= ST_HOLD;
            dly_cnt_r   <= DLY_ZERO;
            p1_prev_r   <= point_1;
            p2_prev_r   <= point_2;
            serve_req_r <= 1'b0;
            serve_dir_r <= 1'b0;
            game_over_r <= 1'b0;
            winner_r    <= WINNER_NONE;
        end else begin
            // Edge registers follow the inputs even while strobes are being ignored.
            p1_prev_r <= point_1;
            p2_prev_r <= point_2;
            case (state_r)
                ST_HOLD: begin
                    if (!pause) begin
                        if (dly_cnt_r == DLY_LAST) begin
                            state_r     <= ST_SERVE;
                            dly_cnt_r   <= DLY_ZERO;
                            serve_req_r <= 1'b1;
                        end else begin
                            dly_cnt_r <= dly_cnt_r + DLY_ONE;
                        end
                    end
                end
                ST_SERVE: begin
                    if (serve_ack) begin
                        state_r     <= ST_PLAY;
                        serve_req_r <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (inc1_s) begin
                        serve_dir_r <= 1'b1;
                        if (win1_s) begin
                            state_r     <= ST_OVER;
                            game_over_r <= 1'b1;
                            winner_r    <= WINNER_P1;
                        end else begin
                            state_r   <= ST_HOLD;
                            dly_cnt_r <= DLY_ZERO;
                        end
                    end else if (inc2_s) begin
                        serve_dir_r <= 1'b0;
                        if (win2_s) begin
                            state_r     <= ST_OVER;
                            game_over_r <= 1'b1;
                            winner_r    <= WINNER_P2;
                        end else begin
                            state_r   <= ST_HOLD;
                            dly_cnt_r <= DLY_ZERO;
                        end
                    end
                end
                ST_OVER: begin
                    game_over_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_HOLD;
                    dly_cnt_r   <= DLY_ZERO;
                    serve_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign serve_req = serve_req_r;
    assign serve_dir = serve_dir_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized traffic against a score model.
module tb_score_keeper;

`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    localparam int TB_WIN = 11;
`else
    localparam int TB_WIN = 99;
`endif
    localparam int TB_DELAY = 4;

    localparam int P_HOLD  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset_n, clear, pause, point_1, point_2, serve_ack;
    logic       serve_req, serve_dir, game_over;
    logic [3:0] score_1_ones, score_1_tens, score_2_ones, score_2_tens;
    logic [1:0] winner;

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(TB_WIN), .SERVE_DELAY(TB_DELAY), .DLY_W(3)) dut (
        .CLOCK_50     (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .pause        (pause),
        .point_1      (point_1),
        .point_2      (point_2),
        .serve_ack    (serve_ack),
        .serve_req    (serve_req),
        .serve_dir    (serve_dir),
        .score_1_ones (score_1_ones),
        .score_1_tens (score_1_tens),
        .score_2_ones (score_2_ones),
        .score_2_tens (score_2_tens),
        .game_over    (game_over),
        .winner       (winner)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: integer scores and a game phase.
    int         m_s1, m_s2, m_cnt, m_phase;
    bit         m_req, m_dir, m_over, m_prev1, m_prev2;
    logic [1:0] m_win;

    function automatic bit wins(input int mine, input int other);
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
        return ((mine >= TB_WIN) && (mine >= other + 2)) || (mine == 99);
`else
        return mine == TB_WIN;
`endif
    endfunction

    function automatic logic [20:0] model_vec();
        return {m_req, m_dir, 4'(m_s1 / 10), 4'(m_s1 % 10), 4'(m_s2 / 10), 4'(m_s2 % 10),
                m_over, m_win};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {serve_req, serve_dir, score_1_tens, score_1_ones, score_2_tens, score_2_ones,
                game_over, winner};
    endfunction

    // Advance the model with the inputs present before the edge, then clock the DUT.
    task automatic step();
        bit e1, e2, won;
        if (!reset_n || clear) begin
            m_s1 = 0; m_s2 = 0; m_cnt = 0; m_phase = P_HOLD;
            m_req = 1'b0; m_dir = 1'b0; m_over = 1'b0; m_win = 2'b00;
            m_prev1 = point_1; m_prev2 = point_2;
        end else begin
            e1 = point_1 && !m_prev1;
            e2 = point_2 && !m_prev2;
            m_prev1 = point_1;
            m_prev2 = point_2;
            if (m_phase == P_HOLD) begin
                if (!pause) begin
                    if (m_cnt == TB_DELAY - 1) begin
                        m_phase = P_SERVE; m_cnt = 0; m_req = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (m_phase == P_SERVE) begin
                if (serve_ack) begin
                    m_phase = P_PLAY; m_req = 1'b0;
                end
            end else if (m_phase == P_PLAY && !pause && (e1 || e2)) begin
                if (e1) begin
                    m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
                    m_dir = 1'b1;
                    won = wins(m_s1, m_s2);
                    m_win = won ? 2'b01 : 2'b00;
                end else begin
                    m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
                    m_dir = 1'b0;
                    won = wins(m_s2, m_s1);
                    m_win = won ? 2'b10 : 2'b00;
                end
                if (won) begin
                    m_phase = P_OVER; m_over = 1'b1;
                end else begin
                    m_phase = P_HOLD; m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic get_to_play(output bit ok);
        int n;
        n = 0;
        while (!serve_req && n < 30) begin
            step();
            n++;
        end
        ok = serve_req;
        serve_ack = 1'b1;
        step();
        serve_ack = 1'b0;
    endtask

    task automatic score(input int k, output bit ok);
        get_to_play(ok);
        if (k == 1) point_1 = 1'b1;
        else        point_2 = 1'b1;
        step();
        point_1 = 1'b0;
        point_2 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; pause = 1'b0;
        point_1 = 1'b1; point_2 = 1'b0; serve_ack = 1'b0;
        step();
        step();
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 21'h0);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_serve_timing();
        int n;
        reset_n = 1'b1;
        n = 0;
        while (!serve_req && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== TB_DELAY) begin
            errors++;
            $display("FAIL serve_delay: got %0d cycles expected %0d", n, TB_DELAY);
        end
        serve_ack = 1'b1;
        step();
        serve_ack = 1'b0;
        checks++;
        if (serve_req !== 1'b0) begin
            errors++;
            $display("FAIL serve_ack_drop: got %b expected 0", serve_req);
        end
        // point_1 was already high through reset: no credit for it.
        step();
        step();
        checks++;
        if ({score_1_tens, score_1_ones} !== 8'h00 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL level_at_reset: got %h expected %h", dut_vec(), model_vec());
        end
        point_1 = 1'b0;
        step();
    endtask

    task automatic test_point_hold();
        int rise_at;
        point_1 = 1'b1;
        step();
        checks++;
        if ({score_1_tens, score_1_ones, serve_dir} !== {8'h01, 1'b1}) begin
            errors++;
            $display("FAIL point_hold_first: got %h expected %h",
                     {score_1_tens, score_1_ones, serve_dir}, {8'h01, 1'b1});
        end
        rise_at = -1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (serve_req && rise_at < 0) rise_at = i;
        end
        point_1 = 1'b0;
        checks++;
        if (rise_at !== TB_DELAY) begin
            errors++;
            $display("FAIL point_reserve: got %0d expected %0d", rise_at, TB_DELAY);
        end
        checks++;
        if (dut_vec() !== model_vec() || m_s1 != 1) begin
            errors++;
            $display("FAIL point_hold_once: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int s1_before, s2_before;
        get_to_play(ok);
        s1_before = m_s1;
        s2_before = m_s2;
        point_1 = 1'b1;
        point_2 = 1'b1;
        step();
        point_1 = 1'b0;
        point_2 = 1'b0;
        checks++;
        if (!ok || m_s1 != s1_before + 1 || m_s2 != s2_before || dut_vec() !== model_vec()
            || serve_dir !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_pause();
        bit ok;
        int n, s1_before;
        get_to_play(ok);
        point_2 = 1'b1;
        step();
        point_2 = 1'b0;
        pause = 1'b1;
        repeat (7) step();
        pause = 1'b0;
        n = 7;
        while (!serve_req && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!ok || n !== TB_DELAY + 7) begin
            errors++;
            $display("FAIL pause_hold: got %0d cycles expected %0d", n, TB_DELAY + 7);
        end
        serve_ack = 1'b1;
        step();
        serve_ack = 1'b0;
        s1_before = m_s1;
        pause = 1'b1;
        point_1 = 1'b1;
        step();
        step();
        pause = 1'b0;
        step();
        step();
        checks++;
        if (m_s1 != s1_before || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL pause_point: got %h expected %h", dut_vec(), model_vec());
        end
        point_1 = 1'b0;
        step();
    endtask

    task automatic test_carry();
        bit ok;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 9; i++) score(1, ok);
        checks++;
        if (!ok || {score_1_tens, score_1_ones} !== 8'h09) begin
            errors++;
            $display("FAIL carry_09: got %h expected 09", {score_1_tens, score_1_ones});
        end
        score(1, ok);
        checks++;
        if (!ok || {score_1_tens, score_1_ones} !== 8'h10 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL carry_10: got %h expected 10", {score_1_tens, score_1_ones});
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 800; i++) begin
            point_1   = ($urandom_range(0, 3) == 0);
            point_2   = ($urandom_range(0, 3) == 0);
            pause     = ($urandom_range(0, 7) == 0);
            serve_ack = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        point_1 = 1'b0; point_2 = 1'b0; pause = 1'b0; serve_ack = 1'b0; clear = 1'b0;
        step();
    endtask

`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    task automatic test_win_rule();
        bit ok, all_ok;
        all_ok = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            score(1, ok); all_ok &= ok;
            score(2, ok); all_ok &= ok;
        end
        score(1, ok); all_ok &= ok;
        checks++;
        if (!all_ok || game_over !== 1'b0 || {score_1_tens, score_1_ones} !== 8'h11) begin
            errors++;
            $display("FAIL win_11_10: got over=%b score=%h expected over=0 score=11",
                     game_over, {score_1_tens, score_1_ones});
        end
        score(1, ok);
        checks++;
        if (!ok || {game_over, winner} !== 3'b101 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL win_12_10: got %h expected %h", dut_vec(), model_vec());
        end
    endtask
`else
    task automatic test_win_rule();
        bit ok, all_ok;
        all_ok = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 98; i++) begin
            score(1, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || game_over !== 1'b0 || {score_1_tens, score_1_ones} !== 8'h98) begin
            errors++;
            $display("FAIL reach_98: got over=%b score=%h expected over=0 score=98",
                     game_over, {score_1_tens, score_1_ones});
        end
        score(1, ok);
        checks++;
        if (!ok || {game_over, winner, score_1_tens, score_1_ones} !== {3'b101, 8'h99}) begin
            errors++;
            $display("FAIL win_99: got %h expected %h",
                     {game_over, winner, score_1_tens, score_1_ones}, {3'b101, 8'h99});
        end
        point_1 = 1'b1;
        step();
        point_1 = 1'b0;
        step();
        checks++;
        if ({score_1_tens, score_1_ones} !== 8'h99 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL saturate_99: got %h expected %h", dut_vec(), model_vec());
        end
    endtask
`endif

    task automatic test_clear();
        int n;
        clear = 1'b1;
        step();
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++;
            $display("FAIL clear_state: got %h expected %h", dut_vec(), 21'h0);
        end
        clear = 1'b0;
        n = 0;
        while (!serve_req && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== TB_DELAY) begin
            errors++;
            $display("FAIL clear_hold: got %0d cycles expected %0d", n, TB_DELAY);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (serve_req !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_handshake: got %h expected %h", dut_vec(), model_vec());
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_serve_timing();
        test_point_hold();
        test_simultaneous();
        test_pause();
        test_carry();
        test_random();
        test_win_rule();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits between the game state machine and the hexdisplay score digits.
- Consumes per-player point strobes, keeps BCD scores for both players, detects the game winner, and sequences the serve hold-off.
- Hands serve permission back to the state machine with a req/ack handshake.
- Drives the four BCD digit buses and the winner LEDs.

Parameters:
- WIN_SCORE, 11: points needed to win; legal range 1..99.
- SERVE_DELAY, 50000000: CLOCK_50 cycles between a point and serve_req (1 s).
- DLY_W, 26: hold-off counter width; must satisfy 2^DLY_W > SERVE_DELAY.

Ports:
- CLOCK_50, in, 1: sole clock; all logic on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- clear, in, 1: synchronous new-game request; level-sensitive, same effect as reset while high.
- pause, in, 1: freezes the hold-off counter and ignores point strobes.
- point_1, in, 1: level from the state machine; its rising edge credits player 1.
- point_2, in, 1: level from the state machine; its rising edge credits player 2.
- serve_ack, in, 1: state machine has launched the ball.
- serve_req, out, 1: serve permitted; held until acked.
- serve_dir, out, 1: 0 = serve toward player 1, 1 = serve toward player 2.
- score_1_ones, out, 4: player 1 BCD ones digit.
- score_1_tens, out, 4: player 1 BCD tens digit.
- score_2_ones, out, 4: player 2 BCD ones digit.
- score_2_tens, out, 4: player 2 BCD tens digit.
- game_over, out, 1: high in state OVER.
- winner, out, 2: LED pattern; 2'b01 = player 1 won, 2'b10 = player 2 won, 00 otherwise.

Behaviour:
- Reset (reset_n=0 at a clock edge) and clear=1 give the same result:
  - all digits 0, serve_req=0, serve_dir=0, game_over=0, winner=00;
  - edge-detect registers set to the current point levels;
  - hold-off counter 0, state HOLD.
  - A reset mid-handshake simply drops serve_req.
- Edge detect: an event occurs when point_k=1 and its registered previous value is 0. A level held high counts once.
- States and transitions:
  - HOLD: counter increments each cycle pause=0. When the counter reaches SERVE_DELAY-1, go to SERVE next cycle and clear the counter. Point events are ignored.
  - SERVE: serve_req=1 (registered). On serve_ack=1, go to PLAY and serve_req=0 on the following edge. serve_ack outside SERVE is ignored. Point events are ignored.
  - PLAY (pause=0): a point event updates the score on the next edge (latency 1). In the same edge:
    - serve_dir = 1 if player 1 scored (serve toward player 2), 0 if player 2 scored;
    - go to OVER if the new score meets the win rule, else to HOLD.
  - OVER: digits frozen, game_over=1, winner set; leave only via clear or reset.
- Simultaneous events on point_1 and point_2 in the same cycle: player 1 is credited, the player 2 event is discarded.
- BCD arithmetic:
  - When ones = 9, ones wraps to 0 and tens increments.
  - At 99 the score saturates; no wrap to 00.
  - Digits never hold values above 9.
- Win rule (without the optional feature): the scorer's new score equals WIN_SCORE.
- Pause:
  - In HOLD, the counter holds its value.
  - In PLAY, point events are dropped, but the edge registers still track the inputs, so an edge that occurs during pause is lost.
  - serve_req, if already high, stays high.

Optional Feature:
- Macro: SCORE_KEEPER_WIN_BY_TWO_EN.
- Defined: a win requires score >= WIN_SCORE and a lead of at least 2 over the opponent. Reaching 99 wins unconditionally, which bounds the game.
- Undefined: first player to reach WIN_SCORE wins; no lead comparison logic is built.

Decomposition:
- Shared package (pong_pkg) holds:
  - the state enum (HOLD, SERVE, PLAY, OVER);
  - the WINNER_P1 = 2'b01 and WINNER_P2 = 2'b10 constants;
  - the BCD digit width constant 4.
- One sub-module: bcd_counter_2d.
  - Two-digit saturating BCD counter with inc and clr inputs.
  - Instantiated once per player.
  - Also exposes a binary value (0..99) for the win and lead compares.

Test Plan (SERVE_DELAY=4 for sim):
- Reset release -> serve_req rises exactly 4 cycles after reset_n goes high; serve_ack pulse -> serve_req=0 next edge, state PLAY.
- Rising edge on point_1 held high for 10 cycles -> score_1 goes 0 to 1 once, serve_dir=1, serve_req reasserts 4 cycles later.
- Player 1 at 09 plus one event -> ones=0, tens=1. Player 1 forced to 99 (WIN_SCORE=99, feature off) -> game_over=1, winner=01; a further event leaves 99.
- point_1 and point_2 rising in the same cycle -> only player 1 increments; serve_dir=1.
- pause=1 during HOLD for 7 cycles -> serve_req delayed by 7 cycles. Point edge during pause -> no score change.
- Feature on, WIN_SCORE=11, score 11-10 -> no win; at 12-10 -> game_over=1, winner=01. Then clear=1 -> all digits 0 and state HOLD next edge.
